// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect input and the
// decode-facing valid/ready channel.
interface fetch_ctrl_if;
    logic [31:0] im_pc;
    logic [31:0] im_code;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_code;

    modport master (
        output im_pc,
        input  im_code,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_code
    );

    modport slave (
        input  im_pc,
        output im_code,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_code
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: issues one word address per cycle, absorbs the
// one-cycle memory latency in a 2-entry skid FIFO and flushes on redirect.
module fetch_ctrl_chk #(
    parameter int FIFO_DEPTH = 2
) (
    input logic       clk,
    input logic       rst_n,
    input logic       redirect,
    input logic       push,
    input logic       pop,
    input logic [1:0] count
);
    // A push into a full FIFO without a same-edge pop would drop a word.
    assert property (@(posedge clk)
        !(rst_n && !redirect && push && !pop && (count == 2'(FIFO_DEPTH))));
endmodule

module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          rst_n,
    fetch_ctrl_if.master bus
);
    logic [31:0] pc_r;
    logic        inflight_v_r;
    logic [31:0] inflight_pc_r;
    logic [31:0] fifo_pc_r   [2];
    logic [31:0] fifo_code_r [2];
    logic        wr_ptr_r;
    logic        rd_ptr_r;
    logic [1:0]  count_r;

    logic        pop_s;
    logic        push_s;
    logic        issue_s;
    logic [2:0]  occ_s;
    logic [1:0]  count_nxt_s;
    logic [31:0] target_s;

    // Handshake decode and the slot-reservation rule for issuing a new read.
    always_comb begin
        pop_s       = (count_r != 2'd0) && bus.out_ready;
        push_s      = inflight_v_r;
        occ_s       = {1'b0, count_r} + {2'b00, inflight_v_r} - {2'b00, pop_s};
        issue_s     = (occ_s <= 3'd1);
        count_nxt_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
        target_s    = bus.redirect_pc & 32'hFFFF_FFFC;
    end

    // PC, in-flight tracker and skid FIFO; reset beats redirect beats issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            inflight_v_r  <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            count_r       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc_r[i]   <= 32'h0000_0000;
                fifo_code_r[i] <= 32'h0000_0000;
            end
        end else if (bus.redirect_valid) begin
            pc_r         <= target_s;
            inflight_v_r <= 1'b0;
            wr_ptr_r     <= 1'b0;
            rd_ptr_r     <= 1'b0;
            count_r      <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_pc_r[wr_ptr_r]   <= inflight_pc_r;
                fifo_code_r[wr_ptr_r] <= bus.im_code;
                wr_ptr_r              <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r      <= count_nxt_s;
            inflight_v_r <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= pc_r;
                pc_r          <= pc_r + 32'd4;
            end
        end
    end

    // Present the FIFO head; zeros while empty.
    always_comb begin
        bus.im_pc     = pc_r;
        bus.out_valid = (count_r != 2'd0);
        if (count_r != 2'd0) begin
            bus.out_pc   = fifo_pc_r[rd_ptr_r];
            bus.out_code = fifo_code_r[rd_ptr_r];
        end else begin
            bus.out_pc   = 32'h0000_0000;
            bus.out_code = 32'h0000_0000;
        end
    end

    fetch_ctrl_chk #(.FIFO_DEPTH(FIFO_DEPTH)) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .redirect (bus.redirect_valid),
        .push     (push_s),
        .pop      (pop_s),
        .count    (count_r)
    );
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: table-driven stream/backpressure vectors plus
// hand-written redirect, stall-redirect, wrap and mid-stream reset sequences.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_ctrl_if bus();

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Synchronous-read memory: mem[i] = 0x1000_0000 + i.
    always @(posedge clk) bus.im_code <= 32'h1000_0000 + (bus.im_pc >> 2);

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        exp_v;
        logic [31:0] exp_pc;
        logic [31:0] exp_im;
    } vec_t;

    vec_t vec [15];

    function automatic logic [31:0] code_of(input logic v, input logic [31:0] pc);
        return v ? (32'h1000_0000 + (pc >> 2)) : 32'h0000_0000;
    endfunction

    task automatic check(input string tag, input string fld,
                         input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got %h expected %h", tag, fld, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare the post-edge outputs.
    task automatic step(input string tag, input logic rst, input logic rv,
                        input logic [31:0] rpc, input logic rdy, input logic ev,
                        input logic [31:0] epc, input logic [31:0] eim);
        rst_n              = rst;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
        @(posedge clk);
        #1;
        check(tag, "out_valid", {31'd0, bus.out_valid}, {31'd0, ev});
        check(tag, "out_pc",    bus.out_pc,   ev ? epc : 32'h0);
        check(tag, "out_code",  bus.out_code, code_of(ev, epc));
        check(tag, "im_pc",     bus.im_pc,    eim);
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b1;

        // Reset, streaming at one word per cycle, then 5 cycles of backpressure.
        vec[0]  = '{1'b0, 1'b1, 1'b0, 32'h00, 32'h00};
        vec[1]  = '{1'b0, 1'b1, 1'b0, 32'h00, 32'h00};
        vec[2]  = '{1'b1, 1'b1, 1'b0, 32'h00, 32'h04};
        vec[3]  = '{1'b1, 1'b1, 1'b1, 32'h00, 32'h08};
        vec[4]  = '{1'b1, 1'b1, 1'b1, 32'h04, 32'h0C};
        vec[5]  = '{1'b1, 1'b1, 1'b1, 32'h08, 32'h10};
        vec[6]  = '{1'b1, 1'b0, 1'b1, 32'h08, 32'h10};
        vec[7]  = '{1'b1, 1'b0, 1'b1, 32'h08, 32'h10};
        vec[8]  = '{1'b1, 1'b0, 1'b1, 32'h08, 32'h10};
        vec[9]  = '{1'b1, 1'b0, 1'b1, 32'h08, 32'h10};
        vec[10] = '{1'b1, 1'b0, 1'b1, 32'h08, 32'h10};
        vec[11] = '{1'b1, 1'b1, 1'b1, 32'h0C, 32'h14};
        vec[12] = '{1'b1, 1'b1, 1'b1, 32'h10, 32'h18};
        vec[13] = '{1'b1, 1'b1, 1'b1, 32'h14, 32'h1C};
        vec[14] = '{1'b1, 1'b1, 1'b1, 32'h18, 32'h20};

        for (int i = 0; i < 15; i++) begin
            step($sformatf("vec%0d", i), vec[i].rst_n, 1'b0, 32'h0, vec[i].rdy,
                 vec[i].exp_v, vec[i].exp_pc, vec[i].exp_im);
        end

        // Redirect while streaming: 0x18 is consumed on the redirect edge, 0x1C is dropped.
        step("redir0", 1'b1, 1'b1, 32'h0000_0103, 1'b1, 1'b0, 32'h0,   32'h100);
        step("redir1", 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   32'h104);
        step("redir2", 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h100, 32'h108);
        step("redir3", 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h104, 32'h10C);

        // Fill the FIFO under stall, then redirect while still stalled.
        step("stall0", 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h104, 32'h10C);
        step("stall1", 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h104, 32'h10C);
        step("stall2", 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   32'h200);
        step("stall3", 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h204);
        step("stall4", 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 32'h208);
        step("stall5", 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 32'h20C);

        // Address wrap past the top of the 32-bit space.
        step("wrap0", 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h0,          32'hFFFF_FFF8);
        step("wrap1", 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,          32'hFFFF_FFFC);
        step("wrap2", 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0000_0000);
        step("wrap3", 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0004);
        step("wrap4", 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 32'h0000_0008);
        step("wrap5", 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0004, 32'h0000_000C);

        // Reset with a full FIFO and a simultaneous redirect: reset wins.
        step("rst0", 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h4, 32'hC);
        step("rst1", 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h4, 32'hC);
        step("rst2", 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0);
        step("rst3", 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 32'h4);
        step("rst4", 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0, 32'h8);
        step("rst5", 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4, 32'hC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
